// File: rtl/cpu6_check_monitor.sv
// cpu6_check_monitor
//   Self-check monitor for cpu6 programs. A loadable table of up to NCHK
//   ordered checks {pc, reg, val} is walked in order: when the sampled fetch
//   PC equals the current entry's PC, the named register is read through the
//   register-file debug port and compared with the expected value. The result
//   is reported as sticky PASS / FAIL / TIMEOUT status with failure details.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   sample_en, pc       one pulse per cpu cycle qualifying the fetch PC
//   cfg_we..cfg_val     table write port (accepted in IDLE only)
//   cfg_num             number of active entries, latched on start
//   start, clear        arm the monitor / return to IDLE from any state
//   rf_raddr, rf_rdata  register-file debug read (data one cycle after address)
//   busy, done          checking in progress / result available
//   pass, fail, timeout sticky result flags
//   fail_idx/got/exp    failing entry index, value read, value expected
module cpu6_check_monitor #(
    parameter int XLEN    = 32,
    parameter int NCHK    = 4,
    parameter int IDXW    = 2,
    parameter int TMO_CYC = 4096,
    parameter int TMOW    = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en,
    input  logic [XLEN-1:0] pc,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [XLEN-1:0] cfg_pc,
    input  logic [4:0]      cfg_reg,
    input  logic [XLEN-1:0] cfg_val,
    input  logic [IDXW:0]   cfg_num,
    input  logic            start,
    input  logic            clear,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [IDXW-1:0] fail_idx,
    output logic [XLEN-1:0] fail_got,
    output logic [XLEN-1:0] fail_exp
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_READ, S_PASS, S_FAIL, S_TMO
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] tbl_pc  [NCHK];
    logic [4:0]      tbl_reg [NCHK];
    logic [XLEN-1:0] tbl_val [NCHK];

    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [IDXW:0]   num, num_nxt, num_sat;
    logic [TMOW-1:0] tmo_cnt, tmo_nxt, tmo_inc;
    logic [IDXW-1:0] fail_idx_nxt;
    logic [XLEN-1:0] fail_got_nxt, fail_exp_nxt;

    logic [XLEN-1:0] cur_pc, cur_val;
    logic [4:0]      cur_reg;
    logic            tbl_we, last_entry;

    assign cur_pc  = tbl_pc[ptr];
    assign cur_reg = tbl_reg[ptr];
    assign cur_val = tbl_val[ptr];

    // The table is only writable while idle; out-of-range indices are dropped.
    assign tbl_we = cfg_we && (state == S_IDLE) && (int'(cfg_idx) < NCHK);

    assign last_entry = (({1'b0, ptr} + (IDXW+1)'(1)) == num);

    // Saturating miss counter: holds once it has reached the limit.
    assign tmo_inc = (int'(tmo_cnt) >= TMO_CYC) ? tmo_cnt : tmo_cnt + TMOW'(1);

    // The read address stays valid through READ so a synchronous register
    // file sees a stable address around the sampling edge.
    assign rf_raddr = (state == S_ARMED || state == S_READ) ? cur_reg : 5'd0;

    assign busy    = (state == S_ARMED) || (state == S_READ);
    assign done    = (state == S_PASS) || (state == S_FAIL) || (state == S_TMO);
    assign pass    = (state == S_PASS);
    assign fail    = (state == S_FAIL);
    assign timeout = (state == S_TMO);

    always_comb begin
        num_sat = cfg_num;
        if (int'(cfg_num) > NCHK)
            num_sat = (IDXW+1)'(NCHK);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt    = state;
        ptr_nxt      = ptr;
        num_nxt      = num;
        tmo_nxt      = tmo_cnt;
        fail_idx_nxt = fail_idx;
        fail_got_nxt = fail_got;
        fail_exp_nxt = fail_exp;

        if (clear) begin
            state_nxt    = S_IDLE;
            ptr_nxt      = '0;
            tmo_nxt      = '0;
            fail_idx_nxt = '0;
            fail_got_nxt = '0;
            fail_exp_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_nxt   = num_sat;
                        ptr_nxt   = '0;
                        tmo_nxt   = '0;
                        state_nxt = (num_sat == '0) ? S_PASS : S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_en) begin
                        if (pc == cur_pc) begin
                            state_nxt = S_READ;
                            tmo_nxt   = '0;
                        end else begin
                            tmo_nxt = tmo_inc;
                            if (int'(tmo_inc) >= TMO_CYC) begin
                                state_nxt    = S_TMO;
                                fail_idx_nxt = ptr;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (rf_rdata != cur_val) begin
                        state_nxt    = S_FAIL;
                        fail_idx_nxt = ptr;
                        fail_got_nxt = rf_rdata;
                        fail_exp_nxt = cur_val;
                    end else if (last_entry) begin
                        state_nxt = S_PASS;
                    end else begin
                        ptr_nxt   = ptr + IDXW'(1);
                        state_nxt = S_ARMED;
                    end
                end
                default: ;  // terminal states hold until clear
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            num      <= '0;
            tmo_cnt  <= '0;
            fail_idx <= '0;
            fail_got <= '0;
            fail_exp <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            num      <= num_nxt;
            tmo_cnt  <= tmo_nxt;
            fail_idx <= fail_idx_nxt;
            fail_got <= fail_got_nxt;
            fail_exp <= fail_exp_nxt;
        end
    end

    // NOTE: the table is a small register array that must read as zero after
    // reset, so it is cleared in the reset branch rather than left to a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHK; i++) begin
                tbl_pc[i]  <= '0;
                tbl_reg[i] <= '0;
                tbl_val[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_pc[cfg_idx]  <= cfg_pc;
            tbl_reg[cfg_idx] <= cfg_reg;
            tbl_val[cfg_idx] <= cfg_val;
        end
    end

endmodule

// File: tb/tb_cpu6_check_monitor.sv
// Self-checking bench for cpu6_check_monitor (TMO_CYC shortened to 8).
module tb_cpu6_check_monitor;

    localparam int XLEN = 32;
    localparam int NCHK = 4;
    localparam int IDXW = 2;
    localparam int TMO  = 8;
    localparam int NVEC = 17;

    logic            clk = 1'b0;
    logic            reset;
    logic            sample_en;
    logic [XLEN-1:0] pc;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic [XLEN-1:0] cfg_pc;
    logic [4:0]      cfg_reg;
    logic [XLEN-1:0] cfg_val;
    logic [IDXW:0]   cfg_num;
    logic            start;
    logic            clear;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            busy, done, pass, fail, timeout;
    logic [IDXW-1:0] fail_idx;
    logic [XLEN-1:0] fail_got, fail_exp;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf_mem [32];

    cpu6_check_monitor #(
        .XLEN(XLEN), .NCHK(NCHK), .IDXW(IDXW), .TMO_CYC(TMO), .TMOW(4)
    ) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .pc(pc),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_reg(cfg_reg),
        .cfg_val(cfg_val), .cfg_num(cfg_num), .start(start), .clear(clear),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_idx(fail_idx), .fail_got(fail_got), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    // Register file with a synchronous debug read port.
    always @(posedge clk) rf_rdata <= rf_mem[rf_raddr];

    typedef struct {
        logic        se;
        logic [31:0] pc;
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  raddr;
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(input logic se, input logic [31:0] p, input logic b,
                                input logic d, input logic ps, input logic [4:0] ra);
        vec_t v;
        v.se = se; v.pc = p; v.busy = b; v.done = d; v.pass = ps; v.raddr = ra;
        return v;
    endfunction

    function automatic logic [4:0] status();
        return {busy, done, pass, fail, timeout};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int idx, input logic [31:0] p, input logic [4:0] r,
                               input logic [31:0] v);
        cfg_we = 1'b1; cfg_idx = IDXW'(idx); cfg_pc = p; cfg_reg = r; cfg_val = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [IDXW:0] n);
        cfg_num = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Apply the PC vector table; in the bad run the final result is FAIL instead of PASS.
    task automatic run_vectors(input bit bad, input string tag);
        logic [4:0] exp_st;
        for (int i = 0; i < NVEC; i++) begin
            sample_en = vec[i].se;
            pc        = vec[i].pc;
            tick();
            exp_st = {vec[i].busy, vec[i].done, bad ? 1'b0 : vec[i].pass,
                      bad ? vec[i].pass : 1'b0, 1'b0};
            check($sformatf("%s_status_%0d", tag, i), 64'(status()), 64'(exp_st));
            check($sformatf("%s_raddr_%0d", tag, i), 64'(rf_raddr), 64'(vec[i].raddr));
        end
        sample_en = 1'b0;
    endtask

    // Random table and PC stream against a pulse-by-pulse model of the check rules.
    task automatic random_trial(input int t);
        logic [31:0] tp [NCHK];
        logic [4:0]  tr [NCHK];
        logic [31:0] tv [NCHK];
        logic [2:0]  cn;
        int          n, m_ptr, m_miss, m_res, m_fidx, post;
        bit          m_read;
        logic [31:0] m_got, m_exp;
        logic        se_r;
        logic [31:0] pc_r;
        logic [4:0]  exp_st;

        do_clear();
        for (int i = 0; i < NCHK; i++) begin
            tp[i] = 32'(($urandom % 8) * 4);
            tr[i] = 5'($urandom % 32);
            tv[i] = $urandom;
            write_entry(i, tp[i], tr[i], tv[i]);
        end
        for (int i = 0; i < NCHK; i++)
            rf_mem[tr[i]] = (($urandom % 6) == 0) ? (tv[i] ^ 32'h1) : tv[i];

        cn = 3'($urandom % 8);
        n  = (int'(cn) > NCHK) ? NCHK : int'(cn);
        m_ptr = 0; m_miss = 0; m_read = 0; m_fidx = 0; m_got = '0; m_exp = '0;
        m_res = (n == 0) ? 1 : 0;  // 0 running, 1 pass, 2 fail, 3 timeout
        do_start(cn);
        check($sformatf("rand%0d_start", t), 64'(status()),
              64'((m_res == 1) ? 5'b01100 : 5'b10000));

        post = 0;
        for (int c = 0; c < 150 && post < 2; c++) begin
            se_r = (($urandom % 2) == 0);
            if (m_res == 0 && ($urandom % 10) < 3) pc_r = tp[m_ptr];
            else                                   pc_r = 32'(($urandom % 8) * 4);
            sample_en = se_r;
            pc        = pc_r;

            if (m_res == 0) begin
                if (m_read) begin
                    m_read = 0;
                    if (rf_mem[tr[m_ptr]] != tv[m_ptr]) begin
                        m_res = 2; m_fidx = m_ptr;
                        m_got = rf_mem[tr[m_ptr]]; m_exp = tv[m_ptr];
                    end else if (m_ptr == n - 1) begin
                        m_res = 1;
                    end else begin
                        m_ptr++;
                    end
                end else if (se_r) begin
                    if (pc_r == tp[m_ptr]) begin
                        m_read = 1; m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss >= TMO) begin
                            m_res = 3; m_fidx = m_ptr;
                        end
                    end
                end
            end else begin
                post++;
            end

            tick();
            exp_st = {m_res == 0, m_res != 0, m_res == 1, m_res == 2, m_res == 3};
            check($sformatf("rand%0d_c%0d_status", t, c), 64'(status()), 64'(exp_st));
            check($sformatf("rand%0d_c%0d_raddr", t, c), 64'(rf_raddr),
                  64'((m_res == 0) ? tr[m_ptr] : 5'd0));
        end
        sample_en = 1'b0;
        check($sformatf("rand%0d_fail_idx", t), 64'(fail_idx), 64'(m_fidx));
        check($sformatf("rand%0d_fail_got", t), 64'(fail_got), 64'(m_got));
        check($sformatf("rand%0d_fail_exp", t), 64'(fail_exp), 64'(m_exp));
    endtask

    initial begin
        int k;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            vec[k] = mk(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 5'd5); k++;
            vec[k] = mk(1'b0, 32'(i * 4), 1'b1, 1'b0, 1'b0, 5'd5); k++;
        end
        vec[12] = mk(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 5'd5);  // match entry0 -> READ
        vec[13] = mk(1'b0, 32'h18, 1'b1, 1'b0, 1'b0, 5'd3);  // READ ok -> entry1
        vec[14] = mk(1'b1, 32'h1c, 1'b1, 1'b0, 1'b0, 5'd3);  // match entry1 -> READ
        vec[15] = mk(1'b0, 32'h1c, 1'b0, 1'b1, 1'b1, 5'd0);  // result two edges later
        vec[16] = mk(1'b0, 32'h1c, 1'b0, 1'b1, 1'b1, 5'd0);  // sticky

        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        reset = 1'b1; sample_en = 1'b0; pc = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_pc = '0; cfg_reg = '0; cfg_val = '0; cfg_num = '0; start = 1'b0; clear = 1'b0;

        // Reset state
        #12;
        check("reset_status", 64'(status()), 64'(0));
        check("reset_raddr", 64'(rf_raddr), 64'(0));
        check("reset_fail_idx", 64'(fail_idx), 64'(0));
        check("reset_fail_got", 64'(fail_got), 64'(0));
        check("reset_fail_exp", 64'(fail_exp), 64'(0));
        #1 reset = 1'b0;
        tick();

        // Directed pass
        write_entry(0, 32'h18, 5'd5, 32'h12345008);
        write_entry(1, 32'h1c, 5'd3, 32'h1234500d);
        rf_mem[5] = 32'h12345008;
        rf_mem[3] = 32'h1234500d;
        do_start(3'd2);
        run_vectors(1'b0, "pass");

        // clear has priority over start
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clear_prio_status", 64'(status()), 64'(0));

        // Mismatch on entry1
        rf_mem[3] = 32'h1234500c;
        do_start(3'd2);
        run_vectors(1'b1, "mism");
        check("mism_fail_idx", 64'(fail_idx), 64'(1));
        check("mism_fail_got", 64'(fail_got), 64'(32'h1234500c));
        check("mism_fail_exp", 64'(fail_exp), 64'(32'h1234500d));

        // clear from FAIL, table retained, restart passes
        do_clear();
        check("clr_status", 64'(status()), 64'(0));
        check("clr_fail_idx", 64'(fail_idx), 64'(0));
        check("clr_fail_got", 64'(fail_got), 64'(0));
        check("clr_fail_exp", 64'(fail_exp), 64'(0));
        rf_mem[3] = 32'h1234500d;
        do_start(3'd2);
        run_vectors(1'b0, "repass");

        // num = 0 passes on the next edge
        do_clear();
        do_start(3'd0);
        check("num0_status", 64'(status()), 64'(5'b01100));

        // Timeout on the 8th non-matching pulse
        do_clear();
        write_entry(0, 32'h100, 5'd7, 32'h0);
        do_start(3'd1);
        for (int p = 1; p <= TMO; p++) begin
            sample_en = 1'b1; pc = 32'h0;
            tick();
            check($sformatf("tmo_pulse%0d", p), 64'(status()),
                  64'((p < TMO) ? 5'b10000 : 5'b01001));
        end
        sample_en = 1'b0;
        check("tmo_fail_idx", 64'(fail_idx), 64'(0));

        // Two entries sharing PC 0x20 match on consecutive pulses
        do_clear();
        write_entry(0, 32'h20, 5'd1, 32'ha1);
        write_entry(1, 32'h20, 5'd2, 32'hb2);
        rf_mem[1] = 32'ha1; rf_mem[2] = 32'hb2;
        do_start(3'd2);
        sample_en = 1'b1; pc = 32'h20; tick();
        sample_en = 1'b0; tick();
        check("dup_mid_status", 64'(status()), 64'(5'b10000));
        check("dup_mid_raddr", 64'(rf_raddr), 64'(2));
        sample_en = 1'b1; tick();
        sample_en = 1'b0; tick();
        check("dup_end_status", 64'(status()), 64'(5'b01100));

        // Write together with start uses the new entry; writes while armed are ignored
        do_clear();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pc = 32'h40; cfg_reg = 5'd4; cfg_val = 32'h44;
        cfg_num = 3'd1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        rf_mem[4] = 32'h44;
        check("wstart_raddr", 64'(rf_raddr), 64'(4));
        write_entry(0, 32'h80, 5'd6, 32'h66);
        check("warmed_raddr", 64'(rf_raddr), 64'(4));
        sample_en = 1'b1; pc = 32'h40; tick();
        sample_en = 1'b0; tick();
        check("warmed_status", 64'(status()), 64'(5'b01100));

        // Asynchronous reset while in READ
        do_clear();
        write_entry(0, 32'h30, 5'd9, 32'h55);
        rf_mem[9] = 32'h55;
        do_start(3'd1);
        sample_en = 1'b1; pc = 32'h30; tick();
        sample_en = 1'b0;
        check("rst_read_raddr", 64'(rf_raddr), 64'(9));
        #2 reset = 1'b1;
        #1;
        check("rst_async_status", 64'(status()), 64'(0));
        check("rst_async_raddr", 64'(rf_raddr), 64'(0));
        #2 reset = 1'b0;
        tick();
        do_start(3'd1);  // entry0 should now be all zero
        check("rst_tbl_raddr", 64'(rf_raddr), 64'(0));
        sample_en = 1'b1; pc = 32'h0; tick();
        sample_en = 1'b0; tick();
        check("rst_tbl_status", 64'(status()), 64'(5'b01100));

        for (int t = 0; t < 40; t++) random_trial(t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
